// File: rtl/up_counter_4bit.sv
// up_counter_4bit: free-running binary up-counter with asynchronous reset.
// Counts RESET_VALUE, RESET_VALUE+1, ... MAX_VALUE, then wraps to 0.
// Optional feature macro: UP_COUNTER_4BIT_WRAP_FLAG_EN adds a registered
// one-cycle 'wrap' pulse, asserted in the cycle after q goes MAX_VALUE -> 0.
module up_counter_4bit #(
  parameter int WIDTH       = 4,
  parameter int RESET_VALUE = 0,
  parameter int MAX_VALUE   = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
`ifdef UP_COUNTER_4BIT_WRAP_FLAG_EN
  ,
  output logic             wrap
`endif
);

  localparam logic [WIDTH-1:0] LP_MAX   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] LP_RESET = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] r_q;
  logic             w_at_max;
  logic             w_at_term;
  logic [WIDTH-1:0] w_q_next;

  // Terminal detection: anything at or above MAX_VALUE reloads 0, so an
  // out-of-range value (not reachable from reset) recovers on the next edge.
  always_comb begin
    w_at_max  = (r_q >= LP_MAX);
    w_at_term = (r_q == LP_MAX);
    w_q_next  = w_at_max ? '0 : (r_q + WIDTH'(1));
  end

  // Count register: asynchronous clear to RESET_VALUE, otherwise advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= LP_RESET;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q = r_q;

`ifdef UP_COUNTER_4BIT_WRAP_FLAG_EN
  logic r_wrap;

  // Wrap flag: registered on the same edge that takes q from MAX_VALUE to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_at_term;
    end
  end

  assign wrap = r_wrap;
`else
  // Terminal flag is only consumed by the optional wrap register.
  logic w_unused;
  assign w_unused = w_at_term;
`endif

endmodule

// File: tb/tb_up_counter_4bit.sv
// Testbench for up_counter_4bit: a default 4-bit instance and a decade
// (MAX_VALUE=9) instance share clock and reset. A model counting edges
// since reset release predicts q (and wrap when the macro is defined).
`timescale 1ns/1ps
module tb_up_counter_4bit;

  logic       clk;
  logic       reset;
  logic [3:0] q16;
  logic [3:0] q10;
`ifdef UP_COUNTER_4BIT_WRAP_FLAG_EN
  logic       wrap16;
  logic       wrap10;
`endif

  int total = 0;
  int bad   = 0;

  up_counter_4bit #(.WIDTH(4), .RESET_VALUE(0), .MAX_VALUE(15)) dut16 (
    .clk   (clk),
    .reset (reset),
    .q     (q16)
`ifdef UP_COUNTER_4BIT_WRAP_FLAG_EN
    ,
    .wrap  (wrap16)
`endif
  );

  up_counter_4bit #(.WIDTH(4), .RESET_VALUE(0), .MAX_VALUE(9)) dut10 (
    .clk   (clk),
    .reset (reset),
    .q     (q10)
`ifdef UP_COUNTER_4BIT_WRAP_FLAG_EN
    ,
    .wrap  (wrap10)
`endif
  );

  // 20 ns clock, rising edges at 10, 30, 50, ...
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end else begin
      $display("ok   %s at %0t: %0d", name, $time, actual);
    end
  endtask

  // Model: number of rising edges seen with reset low since the last release.
  int      n_edges = 0;
  realtime t_pos   = 0;
  realtime t_rel   = 0;

  always @(posedge clk) t_pos = $realtime;
  always @(negedge reset) t_rel = $realtime;

  // Per-cycle compare at the falling edge, away from the active edge.
  always @(negedge clk) begin
    bit stepped;
    int e16, e10;
    stepped = 1'b0;
    if (reset) begin
      n_edges = 0;
    end else if (t_pos > t_rel) begin
      n_edges++;
      stepped = 1'b1;
    end
    e16 = n_edges % 16;
    e10 = n_edges % 10;
    check("model_q16", int'(q16), e16);
    check("model_q10", int'(q10), e10);
`ifdef UP_COUNTER_4BIT_WRAP_FLAG_EN
    check("model_wrap16", int'(wrap16), (stepped && e16 == 0) ? 1 : 0);
    check("model_wrap10", int'(wrap10), (stepped && e10 == 0) ? 1 : 0);
`endif
  end

  initial begin
    int k;
    reset = 1'b1;
    #5;
    check("por_q16", int'(q16), 0);
    check("por_q10", int'(q10), 0);
    #10 reset = 1'b0;                    // t = 15
    #16;                                 // t = 31
    check("first_inc_q16", int'(q16), 1);
    #160;                                // t = 191
    check("q16_at_190", int'(q16), 9);
    check("q10_at_190", int'(q10), 9);
    #20;                                 // t = 211
    check("q16_at_210", int'(q16), 10);
    check("q10_wrap_to_0", int'(q10), 0);
`ifdef UP_COUNTER_4BIT_WRAP_FLAG_EN
    check("wrap10_pulse", int'(wrap10), 1);
    check("wrap16_quiet", int'(wrap16), 0);
`endif
    #80;                                 // t = 291
    check("q16_is_14", int'(q16), 14);
    #20;                                 // t = 311
    check("q16_is_15", int'(q16), 15);
    #20;                                 // t = 331
    check("q16_wraps_0", int'(q16), 0);
`ifdef UP_COUNTER_4BIT_WRAP_FLAG_EN
    check("wrap16_pulse", int'(wrap16), 1);
`endif
    #20;                                 // t = 351
    check("q16_after_wrap", int'(q16), 1);
`ifdef UP_COUNTER_4BIT_WRAP_FLAG_EN
    check("wrap16_drop", int'(wrap16), 0);
`endif

    // Asynchronous reset between edges when q16 == 7.
    for (k = 0; k < 40 && q16 != 4'd7; k++) @(negedge clk);
    check("reach_q7", int'(q16), 7);
    #3 reset = 1'b1;
    #1;
    check("async_clr_q16", int'(q16), 0);
    check("async_clr_q10", int'(q10), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("restart_q16", int'(q16), 1);

    // Reset asserted exactly on a rising edge when q16 == 5.
    for (k = 0; k < 40 && q16 != 4'd5; k++) @(negedge clk);
    check("reach_q5", int'(q16), 5);
    @(posedge clk);
    reset = 1'b1;
    #1;
    check("coincide_q16", int'(q16), 0);
    check("coincide_q10", int'(q10), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
